// File: rtl/lif_scan_scheduler_if.sv
// Request/response/result bundle between the LIF scan scheduler and the
// TPPE array. The scheduler is the master; the upstream/consumer side is the slave.
interface lif_scan_scheduler_if #(
  parameter int VMEM_W = 16,
  parameter int IDX_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [IDX_W-1:0]  req_idx;
  logic              resp_valid;
  logic [VMEM_W-1:0] resp_fast_sum;
  logic [VMEM_W-1:0] resp_corr;
  logic              out_valid;
  logic [IDX_W-1:0]  out_idx;
  logic [VMEM_W-1:0] out_vmem;
  logic              out_spike;

  modport master (
    output req_valid, req_idx, out_valid, out_idx, out_vmem, out_spike,
    input  req_ready, resp_valid, resp_fast_sum, resp_corr
  );

  modport slave (
    input  req_valid, req_idx, out_valid, out_idx, out_vmem, out_spike,
    output req_ready, resp_valid, resp_fast_sum, resp_corr
  );
endinterface

// File: rtl/lif_scan_scheduler.sv
// Time-multiplexed LIF update controller: one shared leak/clamp/fire datapath
// walks every neuron in index order per timestep, keeping membrane potentials
// in a small register file (needs a single-cycle clear, so no block RAM).
module lif_scan_scheduler #(
  parameter int VMEM_W   = 16,
  parameter int N_NEURON = 8,
  parameter int IDX_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear_all,
  input  logic [VMEM_W-1:0]     leak,
  input  logic [VMEM_W-1:0]     threshold,
  lif_scan_scheduler_if.master  bus,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_UPDATE, S_DONE} state_t;

  localparam int SW = VMEM_W + 2;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [VMEM_W-1:0] leak_reg, thr_reg, fsum_reg, corr_reg;
  logic [VMEM_W-1:0] vmem_word [N_NEURON];
  logic [VMEM_W-1:0] out_vmem_reg;
  logic [IDX_W-1:0]  out_idx_reg;
  logic              out_valid_reg, out_spike_reg, done_reg;

  logic              idle_free, start_acc, clear_acc, cap, upd, last;
  logic [VMEM_W-1:0] vmem_cur, result, store_val;
  logic [SW-1:0]     sum_s;
  logic              fire;

  // done is registered, so the scan is still "busy" for the cycle it is shown
  assign idle_free = (state_reg == S_IDLE) && !done_reg;
  assign start_acc = idle_free && start;
  assign clear_acc = idle_free && !start && clear_all;
  assign cap       = (state_reg == S_WAIT) && bus.resp_valid;
  assign upd       = (state_reg == S_UPDATE);
  assign last      = (idx_reg == IDX_W'(N_NEURON - 1));

  assign busy          = (state_reg != S_IDLE) || done_reg;
  assign done          = done_reg;
  assign bus.req_idx   = idx_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_idx   = out_idx_reg;
  assign bus.out_vmem  = out_vmem_reg;
  assign bus.out_spike = out_spike_reg;

  // State and scan index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state, index advance and request strobe
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    bus.req_valid = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (start_acc) begin
          state_next = S_REQ;
          idx_next   = '0;
        end
      end
      S_REQ: begin
        bus.req_valid = 1'b1;
        if (bus.req_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.resp_valid) state_next = S_UPDATE;
      end
      S_UPDATE: begin
        if (last) begin
          state_next = S_DONE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = S_REQ;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Update arithmetic: two guard bits give room for both overflow and a
  // negative result, so the top bit is the sign and the next one the overflow
  always_comb begin
    vmem_cur = vmem_word[idx_reg];
    sum_s    = {2'b00, vmem_cur} + {2'b00, fsum_reg}
             - {2'b00, leak_reg} - {2'b00, corr_reg};
    if (sum_s[SW-1])
      result = '0;
    else if (sum_s[SW-2])
      result = '1;
    else
      result = sum_s[VMEM_W-1:0];
    fire      = (thr_reg != '0) && (result >= thr_reg);
    store_val = fire ? '0 : result;
  end

  // Per-timestep parameters and per-neuron operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leak_reg <= '0;
      thr_reg  <= '0;
      fsum_reg <= '0;
      corr_reg <= '0;
    end else begin
      if (start_acc) begin
        leak_reg <= leak;
        thr_reg  <= threshold;
      end
      if (cap) begin
        fsum_reg <= bus.resp_fast_sum;
        corr_reg <= bus.resp_corr;
      end
    end
  end

  // Registered result strobe and end-of-scan pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_spike_reg <= 1'b0;
      out_idx_reg   <= '0;
      out_vmem_reg  <= '0;
      done_reg      <= 1'b0;
    end else begin
      out_valid_reg <= upd;
      done_reg      <= (state_reg == S_DONE);
      if (upd) begin
        out_idx_reg   <= idx_reg;
        out_vmem_reg  <= result;
        out_spike_reg <= fire;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_NEURON; gi++) begin : g_vmem
      logic [VMEM_W-1:0] entry_reg;
      // One membrane potential: cleared by reset/clear_all, written when scanned
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          entry_reg <= '0;
        else if (clear_acc)
          entry_reg <= '0;
        else if (upd && (idx_reg == IDX_W'(gi)))
          entry_reg <= store_val;
      end
      assign vmem_word[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: tb/tb_lif_scan_scheduler.sv
// Directed bench for lif_scan_scheduler: an upstream model answers requests
// from per-neuron tables, a monitor logs every result strobe with its cycle.
module tb_lif_scan_scheduler;
  localparam int VW = 16;
  localparam int NN = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, clear_all, busy, done;
  logic [VW-1:0] leak, threshold;

  lif_scan_scheduler_if #(.VMEM_W(VW), .IDX_W(IW)) bus();

  lif_scan_scheduler #(.VMEM_W(VW), .N_NEURON(NN), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_all(clear_all),
    .leak(leak), .threshold(threshold), .bus(bus.master),
    .busy(busy), .done(done)
  );

  // Upstream: auto mode answers immediately, manual mode is hand-driven
  logic          auto_mode, man_rdy, man_rsp;
  logic [VW-1:0] fs_tab [NN];
  logic [VW-1:0] cr_tab [NN];
  assign bus.req_ready     = auto_mode ? 1'b1 : man_rdy;
  assign bus.resp_valid    = auto_mode ? 1'b1 : man_rsp;
  assign bus.resp_fast_sum = fs_tab[bus.req_idx];
  assign bus.resp_corr     = cr_tab[bus.req_idx];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_out = 0, n_done = 0, done_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic          busy_prev = 1'b0;
  logic [VW-1:0] log_v [512];
  logic [IW-1:0] log_i [512];
  logic          log_s [512];
  int            log_c [512];

  always @(negedge clk) begin
    if (bus.out_valid && n_out < 512) begin
      log_v[n_out] = bus.out_vmem;
      log_i[n_out] = bus.out_idx;
      log_s[n_out] = bus.out_spike;
      log_c[n_out] = cyc;
      $display("strobe idx=%0d vmem=%0d spike=%0d cyc=%0d", bus.out_idx, bus.out_vmem, bus.out_spike, cyc);
      n_out++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy && !busy_prev) rise_cyc = cyc;
    if (!busy && busy_prev) fall_cyc = cyc;
    busy_prev = busy;
  end

  int total = 0, passed = 0;
  int out_base, done_base, t0;

  // Start a scan, optionally poking start/clear_all k cycles later, and wait for done
  task automatic run_scan(input logic [VW-1:0] lk, input logic [VW-1:0] th,
                          input logic with_clear, input int poke_start, input int poke_clear);
    int k;
    out_base  = n_out;
    done_base = n_done;
    @(negedge clk);
    leak = lk; threshold = th; start = 1'b1; clear_all = with_clear;
    @(negedge clk);
    start = 1'b0; clear_all = 1'b0; t0 = cyc;
    leak = 16'h7777; threshold = 16'h0001;
    k = 0;
    while (k < 200 && !(n_done != done_base && k > 30)) begin
      @(negedge clk);
      k++;
      start     = (k == poke_start);
      clear_all = (k == poke_clear);
    end
    start = 1'b0; clear_all = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (n_done == done_base) $display("FAIL scan_timeout: no done after %0d cycles", k);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; clear_all = 1'b0; leak = '0; threshold = '0;
    auto_mode = 1'b1; man_rdy = 1'b0; man_rsp = 1'b0;
    for (int i = 0; i < NN; i++) begin fs_tab[i] = '0; cr_tab[i] = '0; end
    repeat (2) @(negedge clk);
    total++;
    if ({bus.req_valid, bus.out_valid, bus.out_spike, busy, done} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {bus.req_valid, bus.out_valid, bus.out_spike, busy, done});
    else passed++;
    total++;
    if ({bus.req_idx, bus.out_idx, bus.out_vmem} !== '0)
      $display("FAIL reset_values: req_idx=%0d out_idx=%0d out_vmem=%0d want 0", bus.req_idx, bus.out_idx, bus.out_vmem);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    for (int i = 0; i < NN; i++) begin fs_tab[i] = 16'd10; cr_tab[i] = '0; end
    run_scan(16'd2, 16'd100, 1'b0, -1, -1);
    total++;
    if (n_out - out_base !== 8) $display("FAIL basic_count: got %0d strobes want 8", n_out - out_base);
    else passed++;
    for (int i = 0; i < NN; i++) begin
      total++;
      if ({log_i[out_base+i], log_v[out_base+i], log_s[out_base+i]} !== {IW'(i), 16'd8, 1'b0})
        $display("FAIL basic1_n%0d: idx=%0d vmem=%0d spike=%0d want idx=%0d vmem=8 spike=0",
                 i, log_i[out_base+i], log_v[out_base+i], log_s[out_base+i], i);
      else passed++;
    end
    total++;
    if (log_c[out_base] - t0 !== 3 || log_c[out_base+7] - t0 !== 24)
      $display("FAIL basic_strobe_time: first=+%0d last=+%0d want +3 +24", log_c[out_base] - t0, log_c[out_base+7] - t0);
    else passed++;
    total++;
    if (done_cyc - t0 !== 25 || n_done - done_base !== 1)
      $display("FAIL basic_done: at +%0d count %0d want +25 count 1", done_cyc - t0, n_done - done_base);
    else passed++;
    total++;
    if (rise_cyc - t0 !== 0 || fall_cyc - t0 !== 26)
      $display("FAIL basic_busy: rise +%0d fall +%0d want +0 +26", rise_cyc - t0, fall_cyc - t0);
    else passed++;
    run_scan(16'd2, 16'd100, 1'b0, -1, -1);
    for (int i = 0; i < NN; i++) begin
      total++;
      if ({log_i[out_base+i], log_v[out_base+i], log_s[out_base+i]} !== {IW'(i), 16'd16, 1'b0})
        $display("FAIL basic2_n%0d: vmem=%0d spike=%0d want 16 0", i, log_v[out_base+i], log_s[out_base+i]);
      else passed++;
    end
  endtask

  task automatic test_fire;
    logic [VW-1:0] ev [NN];
    logic          es [NN];
    // Preload neuron 3 to 95 and neuron 5 to 92 (others stay at 16)
    for (int i = 0; i < NN; i++) begin fs_tab[i] = '0; cr_tab[i] = '0; end
    fs_tab[3] = 16'd79; fs_tab[5] = 16'd76;
    run_scan(16'd0, 16'd0, 1'b0, -1, -1);
    // 95+10-2 = 103 fires; 92+10-2 = 100 hits threshold exactly and fires
    for (int i = 0; i < NN; i++) fs_tab[i] = 16'd10;
    ev = '{16'd24, 16'd24, 16'd24, 16'd103, 16'd24, 16'd100, 16'd24, 16'd24};
    es = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    run_scan(16'd2, 16'd100, 1'b0, -1, -1);
    for (int i = 0; i < NN; i++) begin
      total++;
      if ({log_i[out_base+i], log_v[out_base+i], log_s[out_base+i]} !== {IW'(i), ev[i], es[i]})
        $display("FAIL fire_n%0d: vmem=%0d spike=%0d want %0d %0d", i, log_v[out_base+i], log_s[out_base+i], ev[i], es[i]);
      else passed++;
    end
    // Fired neurons were reset to 0
    for (int i = 0; i < NN; i++) fs_tab[i] = '0;
    ev = '{16'd24, 16'd24, 16'd24, 16'd0, 16'd24, 16'd0, 16'd24, 16'd24};
    run_scan(16'd0, 16'd100, 1'b0, -1, -1);
    for (int i = 0; i < NN; i++) begin
      total++;
      if ({log_i[out_base+i], log_v[out_base+i], log_s[out_base+i]} !== {IW'(i), ev[i], 1'b0})
        $display("FAIL fire_after_n%0d: vmem=%0d spike=%0d want %0d 0", i, log_v[out_base+i], log_s[out_base+i], ev[i]);
      else passed++;
    end
  endtask

  task automatic test_clamp;
    logic [VW-1:0] ev [NN];
    // Bring neuron 0 to 3 and neuron 1 to 65530
    for (int i = 0; i < NN; i++) begin fs_tab[i] = '0; cr_tab[i] = '0; end
    cr_tab[0] = 16'd21; fs_tab[1] = 16'd65506;
    run_scan(16'd0, 16'd0, 1'b0, -1, -1);
    ev = '{16'd3, 16'd65530, 16'd24, 16'd0, 16'd24, 16'd0, 16'd24, 16'd24};
    for (int i = 0; i < NN; i++) begin
      total++;
      if ({log_v[out_base+i], log_s[out_base+i]} !== {ev[i], 1'b0})
        $display("FAIL clamp_pre_n%0d: vmem=%0d spike=%0d want %0d 0", i, log_v[out_base+i], log_s[out_base+i], ev[i]);
      else passed++;
    end
    // leak=5: 3+0-5-1 underflows to 0; neuron 1 holds with fs=5
    cr_tab[0] = 16'd1; fs_tab[1] = 16'd5;
    run_scan(16'd5, 16'd0, 1'b0, -1, -1);
    ev = '{16'd0, 16'd65530, 16'd19, 16'd0, 16'd19, 16'd0, 16'd19, 16'd19};
    for (int i = 0; i < NN; i++) begin
      total++;
      if (log_v[out_base+i] !== ev[i])
        $display("FAIL clamp_under_n%0d: vmem=%0d want %0d", i, log_v[out_base+i], ev[i]);
      else passed++;
    end
    // 65530+100 saturates; threshold 0 means no spike
    cr_tab[0] = '0; fs_tab[1] = 16'd100;
    run_scan(16'd0, 16'd0, 1'b0, -1, -1);
    ev = '{16'd0, 16'd65535, 16'd19, 16'd0, 16'd19, 16'd0, 16'd19, 16'd19};
    for (int i = 0; i < NN; i++) begin
      total++;
      if ({log_v[out_base+i], log_s[out_base+i]} !== {ev[i], 1'b0})
        $display("FAIL clamp_sat_n%0d: vmem=%0d spike=%0d want %0d 0", i, log_v[out_base+i], log_s[out_base+i], ev[i]);
      else passed++;
    end
  endtask

  task automatic test_handshake;
    logic [VW-1:0] ev [NN];
    logic          stall_ok;
    int            rsp_cyc;
    int            k;
    for (int i = 0; i < NN; i++) begin fs_tab[i] = VW'(i + 1); cr_tab[i] = '0; end
    ev = '{16'd1, 16'd65535, 16'd22, 16'd4, 16'd24, 16'd6, 16'd26, 16'd27};
    auto_mode = 1'b0; man_rdy = 1'b0; man_rsp = 1'b0;
    stall_ok = 1'b1; rsp_cyc = 0;
    out_base = n_out; done_base = n_done;
    @(negedge clk);
    leak = '0; threshold = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NN; i++) begin
      if (i == 2) begin
        for (int j = 0; j < 5; j++) begin
          man_rsp = (j == 1);
          @(negedge clk);
          if (!(bus.req_valid === 1'b1 && bus.req_idx === 3'd2 && bus.out_valid === 1'b0)) stall_ok = 1'b0;
        end
        man_rsp = 1'b0;
      end
      man_rdy = 1'b1;
      @(negedge clk);
      man_rdy = 1'b0;
      if (i == 2) repeat (2) @(negedge clk);
      man_rsp = 1'b1;
      if (i == 2) rsp_cyc = cyc;
      @(negedge clk);
      man_rsp = 1'b0;
      @(negedge clk);
    end
    k = 0;
    while (n_done == done_base && k < 10) begin @(negedge clk); k++; end
    auto_mode = 1'b1;
    total++;
    if (!stall_ok) $display("FAIL hs_stall: req not held stable at idx 2 (got valid=%b idx=%0d) want valid=1 idx=2", bus.req_valid, bus.req_idx);
    else passed++;
    total++;
    if (n_out - out_base !== 8 || n_done - done_base !== 1)
      $display("FAIL hs_count: strobes %0d done %0d want 8 1", n_out - out_base, n_done - done_base);
    else passed++;
    total++;
    if (log_c[out_base+2] - rsp_cyc !== 2)
      $display("FAIL hs_latency: result %0d cycles after resp want 2", log_c[out_base+2] - rsp_cyc);
    else passed++;
    for (int i = 0; i < NN; i++) begin
      total++;
      if ({log_i[out_base+i], log_v[out_base+i]} !== {IW'(i), ev[i]})
        $display("FAIL hs_n%0d: idx=%0d vmem=%0d want %0d %0d", i, log_i[out_base+i], log_v[out_base+i], i, ev[i]);
      else passed++;
    end
  endtask

  task automatic test_conflicts;
    logic [VW-1:0] ev [NN];
    for (int i = 0; i < NN; i++) begin fs_tab[i] = '0; cr_tab[i] = '0; end
    ev = '{16'd1, 16'd65535, 16'd22, 16'd4, 16'd24, 16'd6, 16'd26, 16'd27};
    // start and clear_all in the middle of a scan
    run_scan(16'd0, 16'd0, 1'b0, 10, 12);
    total++;
    if (n_out - out_base !== 8 || n_done - done_base !== 1)
      $display("FAIL conf_mid_count: strobes %0d done %0d want 8 1", n_out - out_base, n_done - done_base);
    else passed++;
    for (int i = 0; i < NN; i++) begin
      total++;
      if (log_v[out_base+i] !== ev[i])
        $display("FAIL conf_mid_n%0d: vmem=%0d want %0d", i, log_v[out_base+i], ev[i]);
      else passed++;
    end
    // start in the done cycle (still busy)
    run_scan(16'd0, 16'd0, 1'b0, 25, -1);
    total++;
    if (n_out - out_base !== 8 || n_done - done_base !== 1)
      $display("FAIL conf_done_start: strobes %0d done %0d want 8 1", n_out - out_base, n_done - done_base);
    else passed++;
    // start together with clear_all: scan wins, nothing cleared
    run_scan(16'd0, 16'd0, 1'b1, -1, -1);
    for (int i = 0; i < NN; i++) begin
      total++;
      if (log_v[out_base+i] !== ev[i])
        $display("FAIL conf_both_n%0d: vmem=%0d want %0d", i, log_v[out_base+i], ev[i]);
      else passed++;
    end
    // clear_all alone in IDLE
    @(negedge clk); clear_all = 1'b1;
    @(negedge clk); clear_all = 1'b0;
    run_scan(16'd0, 16'd0, 1'b0, -1, -1);
    for (int i = 0; i < NN; i++) begin
      total++;
      if (log_v[out_base+i] !== 16'd0)
        $display("FAIL conf_clear_n%0d: vmem=%0d want 0", i, log_v[out_base+i]);
      else passed++;
    end
  endtask

  task automatic test_reset_midscan;
    for (int i = 0; i < NN; i++) begin fs_tab[i] = 16'd5; cr_tab[i] = '0; end
    run_scan(16'd0, 16'd0, 1'b0, -1, -1);
    done_base = n_done;
    @(negedge clk);
    leak = '0; threshold = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    // now in UPDATE of neuron 0
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.req_valid, bus.out_valid, bus.out_spike, busy, done} !== 5'b0)
      $display("FAIL rst_mid_flags: got %b want 00000", {bus.req_valid, bus.out_valid, bus.out_spike, busy, done});
    else passed++;
    total++;
    if ({bus.req_idx, bus.out_idx, bus.out_vmem} !== '0)
      $display("FAIL rst_mid_values: req_idx=%0d out_idx=%0d out_vmem=%0d want 0", bus.req_idx, bus.out_idx, bus.out_vmem);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (n_done - done_base !== 0) $display("FAIL rst_mid_done: got %0d done pulses want 0", n_done - done_base);
    else passed++;
    for (int i = 0; i < NN; i++) fs_tab[i] = '0;
    run_scan(16'd0, 16'd0, 1'b0, -1, -1);
    for (int i = 0; i < NN; i++) begin
      total++;
      if ({log_i[out_base+i], log_v[out_base+i]} !== {IW'(i), 16'd0})
        $display("FAIL rst_after_n%0d: idx=%0d vmem=%0d want %0d 0", i, log_i[out_base+i], log_v[out_base+i], i);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fire();
    test_clamp();
    test_handshake();
    test_conflicts();
    test_reset_midscan();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/lif_scan_scheduler.md
# lif_scan_scheduler

Time-multiplexed LIF neuron update controller for the multi-neuron TPPE array. On each timestep `start` pulse, it scans all `N_NEURON` neurons in index order. For each neuron it requests that neuron's accumulated fast sum and correction from the upstream TPPE side. It then applies the leak/clamp update against a local membrane-potential array, compares against threshold and emits a per-neuron spike result. It replaces one pseudo-accumulator per neuron with one shared update datapath plus a register-file of membrane potentials.

## Interface
- `VMEM_W`, 16, membrane potential / operand width (unsigned)
- `N_NEURON`, 8, neurons per scan; ≥2
- `IDX_W`, 3, neuron index width; must satisfy 2^IDX_W ≥ N_NEURON

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin one timestep scan (pulse; sampled only in IDLE)
- `clear_all`  in  1  zero all stored vmem (sampled only in IDLE; `start` has priority)
- `leak`  in  VMEM_W  leak per timestep; latched at accepted `start`
- `threshold`  in  VMEM_W  fire threshold; latched at accepted `start`; 0 disables firing
- `req_valid`  out  1  request operands for neuron `req_idx`
- `req_ready`  in  1  upstream accepts request
- `req_idx`  out  IDX_W  neuron being requested
- `resp_valid`  in  1  operands valid
- `resp_fast_sum`  in  VMEM_W  fast sum for current neuron
- `resp_corr`  in  VMEM_W  correction term for current neuron
- `out_valid`  out  1  one-cycle result strobe
- `out_idx`  out  IDX_W  neuron of result
- `out_vmem`  out  VMEM_W  post-update vmem (before fire reset)
- `out_spike`  out  1  neuron fired
- `busy`  out  1  high in any state but IDLE
- `done`  out  1  one-cycle pulse at end of scan

## Operation
- States: IDLE, REQ, WAIT, UPDATE, DONE.
  - IDLE: `start`=1 → latch `leak`/`threshold`, idx←0, →REQ. Else `clear_all`=1 → all vmem[i]←0 in one cycle.
  - REQ: `req_valid`=1, `req_idx`=idx. Held stable until `req_valid && req_ready`, then →WAIT.
  - WAIT: on `resp_valid`, capture `resp_fast_sum`/`resp_corr`, →UPDATE. `resp_valid` in any other state is ignored.
  - UPDATE: compute and write vmem[idx]. Drive `out_*` with `out_valid`=1. If idx==N_NEURON-1, →DONE; else idx+1, →REQ.
  - DONE: `done`=1, →IDLE.
- Arithmetic:
  - s = vmem[idx] + fast_sum − leak − corr, evaluated signed at VMEM_W+2 bits with all operands zero-extended.
  - s<0 → 0 (underflow clamp).
  - s>2^VMEM_W−1 → 2^VMEM_W−1 (saturate).
  - Otherwise s[VMEM_W−1:0].
- Fire: `out_spike` = (threshold≠0) && (result ≥ threshold), unsigned compare. On fire, stored vmem[idx]←0 while `out_vmem` still reports the result. Otherwise vmem[idx]←result.
- `start` and `clear_all` are ignored while `busy`. Neurons are never skipped or reordered.

## Timing
- Reset (async, immediate):
  - State←IDLE, idx←0, all vmem[i]←0, latched leak/threshold←0.
  - `req_valid`, `out_valid`, `out_spike`, `busy`, `done` = 0.
  - `req_idx`, `out_idx`, `out_vmem` = 0.
- Reset mid-scan aborts the scan with no `done`. Partial vmem updates are lost (array zeroed).
- `busy` rises the cycle after `start` is sampled and falls the cycle after `done`.
- Per-neuron minimum: 3 cycles (REQ with `req_ready`=1, WAIT with `resp_valid`=1 in first WAIT cycle, UPDATE).
- With no stalls: first `out_valid` 3 cycles after the `start` edge; `done` 3·N_NEURON+1 cycles after the `start` edge; `busy` low at +3·N_NEURON+2.
- `req_ready` low stalls REQ indefinitely with `req_idx` stable. `resp_valid` low stalls WAIT indefinitely.
- `out_*` are registered and valid only while `out_valid`=1. `out_idx`/`out_vmem`/`out_spike` hold last values otherwise.
- `leak`/`threshold` changes during a scan have no effect until the next `start`.

## Test plan
- Reset: assert `rst_n`=0 mid-UPDATE → all outputs 0 within the same cycle; the next scan with sum=0, leak=0 reports `out_vmem`=0 for every idx.
- Basic scan, N=8, leak=2, threshold=100, every fast_sum=10, corr=0, no stalls:
  - Scan 1 → 8 strobes, idx 0..7 in order, `out_vmem`=8, no spikes, `done` at +25 cycles.
  - Scan 2 → `out_vmem`=16.
- Fire: neuron 3 preloaded to 95 via prior scans, fast_sum=10, leak=2, corr=0, threshold=100 → `out_vmem`=103, `out_spike`=1. The next scan with sum=0, leak=0 reports 0 for idx 3.
- Clamp/saturate:
  - vmem=3, sum=0, leak=5, corr=1 → 0.
  - vmem=65530, sum=100, leak=0, threshold=0 → 65535, no spike.
- Handshake: hold `req_ready`=0 for 5 cycles on idx 2 → `req_valid`=1 and `req_idx`=2 stable, no `out_valid`. A `resp_valid` pulse during REQ is ignored. The result arrives 2 cycles after the later `resp_valid`.
- Control conflicts:
  - `start` during scan → ignored, single `done`.
  - `clear_all` during scan → ignored.
  - `start`+`clear_all` in IDLE → scan starts and vmem is not cleared.
  - `clear_all` alone → next scan with zero operands reports all 0.
